// File: rtl/cam_pkg.sv
// ============================================================================
// Module      : cam_pkg
// Description : Shared constants and types for the 32-entry CAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_pkg;

    localparam int CAM_DATA_WIDTH = 32;
    localparam int CAM_ADDR_WIDTH = 5;
    localparam int CAM_DEPTH      = 32;

    typedef logic [CAM_DATA_WIDTH-1:0] cam_data_t;
    typedef logic [CAM_ADDR_WIDTH-1:0] cam_addr_t;
    typedef logic [CAM_ADDR_WIDTH:0]   cam_cnt_t;

endpackage : cam_pkg

`default_nettype wire

// File: rtl/cam_prio_enc.sv
// ============================================================================
// Module      : cam_prio_enc
// Description : Combinational priority encoder, lowest set bit wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_prio_enc
    import cam_pkg::*;
#(
    parameter int DEPTH      = CAM_DEPTH,
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH
) (
    input  logic [DEPTH-1:0]      match_i,
    output logic                  hit_o,
    output logic [ADDR_WIDTH-1:0] idx_o
);

    // Scan downward so the lowest matching index is the last one assigned.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_i[i]) begin
                hit_o = 1'b1;
                idx_o = ADDR_WIDTH'(i);
            end
        end
    end

endmodule : cam_prio_enc

`default_nettype wire

// File: rtl/cam_array.sv
// ============================================================================
// Module      : cam_array
// Description : CAM storage with written flags, occupancy and registered search.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_array
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH = CAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int SIZE       = DATA_WIDTH * DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  write_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  invalidate_en_i,
    input  logic [ADDR_WIDTH-1:0] inv_addr_i,
    input  logic                  search_en_i,
    input  logic [DATA_WIDTH-1:0] search_data_i,
    output logic                  search_valid_o,
    output logic                  search_hit_o,
    output logic [ADDR_WIDTH-1:0] search_addr_o,
    output logic [SIZE-1:0]       data_o,
    output logic [DEPTH-1:0]      written_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]                 written_q, written_d;
    logic [ADDR_WIDTH:0]              count_q, count_d;
    logic                             valid_q, hit_q;
    logic [ADDR_WIDTH-1:0]            addr_q;
    logic [DEPTH-1:0]                 w_match;
    logic                             w_hit;
    logic [ADDR_WIDTH-1:0]            w_idx;
    logic                             w_inc, w_dec;

    // Invalidate is applied first so a same-address write wins.
    always_comb begin
        mem_d     = mem_q;
        written_d = written_q;
        if (invalidate_en_i) written_d[inv_addr_i] = 1'b0;
        if (write_en_i) begin
            mem_d[wr_addr_i]     = wr_data_i;
            written_d[wr_addr_i] = 1'b1;
        end
    end

    assign w_inc = write_en_i & ~written_q[wr_addr_i];
    assign w_dec = invalidate_en_i & written_q[inv_addr_i]
                 & ~(write_en_i && (wr_addr_i == inv_addr_i));

    always_comb begin
        count_d = count_q;
        if (w_inc && !w_dec && count_q != (ADDR_WIDTH+1)'(DEPTH))
            count_d = count_q + 1'b1;
        else if (w_dec && !w_inc && count_q != '0)
            count_d = count_q - 1'b1;
    end

    // Search sees only the pre-edge contents; stale unwritten data never matches.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            w_match[i] = written_q[i] && (mem_q[i] == search_data_i);
    end

    cam_prio_enc #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_prio_enc (
        .match_i (w_match),
        .hit_o   (w_hit),
        .idx_o   (w_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q     <= '0;
            written_q <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            hit_q     <= 1'b0;
            addr_q    <= '0;
        end else begin
            mem_q     <= mem_d;
            written_q <= written_d;
            count_q   <= count_d;
            valid_q   <= search_en_i;
            hit_q     <= search_en_i & w_hit;
            addr_q    <= search_en_i ? w_idx : '0;
        end
    end

    assign data_o         = mem_q;
    assign written_o      = written_q;
    assign count_o        = count_q;
    assign full_o         = (count_q == (ADDR_WIDTH+1)'(DEPTH));
    assign search_valid_o = valid_q;
    assign search_hit_o   = hit_q;
    assign search_addr_o  = addr_q;

endmodule : cam_array

`default_nettype wire

// File: doc/cam_array.md
Name: cam_array

Overview:
- Storage and search stage of the 32-entry CAM.
- Holds DEPTH data words with per-entry written flags and accepts one write and one invalidate per cycle.
- Performs a registered content search that returns the matching address.
- Drives the flattened data bus and written vector consumed directly by the downstream read mux (cam_mux), and reports occupancy.

Parameters:
- DATA_WIDTH, 32, width of one entry.
- ADDR_WIDTH, 5, entry address width.
- DEPTH, 1<<ADDR_WIDTH, number of entries.
- SIZE, DATA_WIDTH*DEPTH, width of flattened data bus.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- write_en_i  in  1  write wr_data_i into entry wr_addr_i.
- wr_addr_i  in  ADDR_WIDTH  write address.
- wr_data_i  in  DATA_WIDTH  write data.
- invalidate_en_i  in  1  clear written flag of entry inv_addr_i.
- inv_addr_i  in  ADDR_WIDTH  invalidate address.
- search_en_i  in  1  start a search for search_data_i.
- search_data_i  in  DATA_WIDTH  search key.
- search_valid_o  out  1  search result valid, one cycle after search_en_i.
- search_hit_o  out  1  at least one written entry matched the key.
- search_addr_o  out  ADDR_WIDTH  lowest matching index; 0 on miss.
- data_o  out  SIZE  entry i at bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]; feeds cam_mux data_i.
- written_o  out  DEPTH  per-entry written flags; feeds cam_mux written_i.
- count_o  out  ADDR_WIDTH+1  number of written entries (0..DEPTH).
- full_o  out  1  count_o == DEPTH, combinational from the count register.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - written_o=0, data_o=0, count_o=0, full_o=0.
  - search_valid_o=0, search_hit_o=0, search_addr_o=0.
  - Reset overrides every other input in that cycle.
  - Reset mid-search drops the pending result: search_valid_o=0 in the following cycle.
- Write: when write_en_i=1 at edge N, entry wr_addr_i gets wr_data_i and its written bit is set. Both are visible on data_o and written_o after edge N (zero extra latency). Rewriting an already-written entry overwrites its data and leaves count unchanged.
- Invalidate: when invalidate_en_i=1, the written bit of inv_addr_i clears. Data is retained, not zeroed. Invalidating an unwritten entry is a no-op.
- Write and invalidate in the same cycle:
  - Same address: write wins; entry ends written with new data.
  - Different addresses: both take effect.
- Count update per edge: count_next = count + (write to previously-unwritten entry) - (invalidate of written entry whose address differs from the write address). The result never goes below 0 or above DEPTH.
- Search:
  - Compare search_data_i against all entries whose written bit is set.
  - Priority-encode, lowest index wins.
  - Register the result: search_valid_o=1 exactly one cycle after search_en_i, otherwise 0.
  - Back-to-back searches are allowed every cycle (fully pipelined, one result per cycle).
  - A search uses pre-edge state: a write or invalidate in the same cycle as search_en_i is not seen by that search.
  - Unwritten entries never match, even if their stale data equals the key.
- No internal FSM beyond the search valid pipeline bit. Outputs are registered except full_o.

Decomposition:
- Package cam_pkg holds:
  - Constants CAM_DATA_WIDTH=32, CAM_ADDR_WIDTH=5, CAM_DEPTH=32.
  - Typedefs cam_data_t, cam_addr_t, cam_cnt_t (ADDR_WIDTH+1 bits).
- Sub-module cam_prio_enc: DEPTH-bit match vector in, hit and lowest-set-bit index out, purely combinational. Instantiated once before the search result register.

Test Plan:
- Reset then idle -> written_o=0, count_o=0, full_o=0, search_valid_o=0. Search for 0x0 next cycle -> valid=1, hit=0, addr=0.
- Write 0xDEADBEEF to addr 7 -> next cycle written_o[7]=1, data_o[255:224]=0xDEADBEEF, count_o=1. Search 0xDEADBEEF -> hit=1, addr=7.
- Write 0xA5A5A5A5 to addrs 3 and 20, search 0xA5A5A5A5 -> hit=1, addr=3. Invalidate 3, search again -> hit=1, addr=20.
- Same cycle: write 0x11 to addr 4, invalidate addr 4, search 0x11 -> search result hit=0 (old state). Next cycle written_o[4]=1, count_o incremented by 1.
- Write all 32 addresses -> count_o=32, full_o=1. Rewrite addr 0 -> count stays 32. Invalidate addr 31 with write to addr 31 -> count 32. Invalidate addr 31 alone -> count 31, full_o=0.
- Issue search_en_i with a matching key, assert rst_i the next cycle -> search_valid_o=0, written_o=0, count_o=0 after that edge.
